// File: rtl/enemy_hit_judge.sv
// Player/enemy-bullet hit judge: overlap test, lives, invulnerability window and game-over FSM.
// Optional macro HIT_BLINK_EN blinks the player plane while invulnerable.
module enemy_hit_judge #(
   parameter int LIVES_INIT    = 3,
   parameter int INVULN_FRAMES = 60,
   parameter int PLANE_W       = 40,
   parameter int PLANE_H       = 40
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic [9:0] eb_x,
   input  logic [9:0] eb_y,
   input  logic       enemybullet_exist,
   input  logic [9:0] pp_x,
   input  logic [9:0] pp_y,
   output logic       collide,
   output logic       player_hit,
   output logic [2:0] lives,
   output logic       invuln,
   output logic       game_over,
   output logic       player_visible
);

   typedef enum logic [1:0] {
      ALIVE  = 2'd0,
      INVULN = 2'd1,
      OVER   = 2'd2
   } state_t;

   state_t      state_r;
   logic [7:0]  cnt_r;
`ifdef HIT_BLINK_EN
   logic [1:0]  blink_r;
`endif

   logic [10:0] ex_s, ey_s, px_s, py_s, sy_s;
   logic        overlap_s;
   logic        hit_s;

   // Overlap of the 10x40 bullet box (virtual y shifted by one screen) with the plane box.
   always_comb begin
      ex_s = {1'b0, eb_x};
      ey_s = {1'b0, eb_y};
      px_s = {1'b0, pp_x};
      py_s = {1'b0, pp_y};
      sy_s = ey_s - 11'd480;
      overlap_s = (ey_s >= 11'd480) && (ey_s <= 11'd960)
               && (ex_s < px_s + 11'(PLANE_W)) && (ex_s + 11'd10 > px_s)
               && (sy_s < py_s + 11'(PLANE_H)) && (sy_s + 11'd40 > py_s);
      hit_s = frame_tick && enemybullet_exist && overlap_s && collide && (state_r == ALIVE);
   end

   // Life/invulnerability FSM with the collide handshake and all registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r        <= ALIVE;
         lives          <= 3'(LIVES_INIT);
         cnt_r          <= 8'd0;
         collide        <= 1'b1;
         player_hit     <= 1'b0;
         invuln         <= 1'b0;
         game_over      <= 1'b0;
         player_visible <= 1'b1;
`ifdef HIT_BLINK_EN
         blink_r        <= 2'd0;
`endif
      end else begin
         player_hit <= 1'b0;
         // Bullet stage acknowledges by retiring the bullet; release on that edge.
         if (!collide && !enemybullet_exist) begin
            collide <= 1'b1;
         end
         case (state_r)
            ALIVE: begin
               if (hit_s) begin
                  lives      <= lives - 3'd1;
                  player_hit <= 1'b1;
                  collide    <= 1'b0;
                  if (lives == 3'd1) begin
                     state_r        <= OVER;
                     game_over      <= 1'b1;
                     player_visible <= 1'b0;
                  end else begin
                     state_r <= INVULN;
                     cnt_r   <= 8'(INVULN_FRAMES);
                     invuln  <= 1'b1;
`ifdef HIT_BLINK_EN
                     player_visible <= 1'b0;
                     blink_r        <= 2'd0;
`endif
                  end
               end
            end
            INVULN: begin
               if (frame_tick) begin
                  cnt_r <= cnt_r - 8'd1;
                  if (cnt_r == 8'd1) begin
                     state_r <= ALIVE;
                     invuln  <= 1'b0;
`ifdef HIT_BLINK_EN
                     player_visible <= 1'b1;
`endif
                  end else begin
`ifdef HIT_BLINK_EN
                     blink_r <= blink_r + 2'd1;
                     if (blink_r == 2'd3) begin
                        player_visible <= ~player_visible;
                     end
`endif
                  end
               end
            end
            OVER: begin
               game_over      <= 1'b1;
               player_visible <= 1'b0;
            end
            default: begin
               state_r <= ALIVE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_enemy_hit_judge.sv
// Self-checking bench for enemy_hit_judge: overlap vector table plus hand-written
// sequences for collide handshake, invulnerability timing, game over and async reset.
module tb_enemy_hit_judge;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       frame_tick = 1'b0;
   logic [9:0] eb_x = 10'd0;
   logic [9:0] eb_y = 10'd0;
   logic       enemybullet_exist = 1'b0;
   logic [9:0] pp_x = 10'd0;
   logic [9:0] pp_y = 10'd0;
   logic       collide;
   logic       player_hit;
   logic [2:0] lives;
   logic       invuln;
   logic       game_over;
   logic       player_visible;

   int n_chk  = 0;
   int n_fail = 0;

   enemy_hit_judge dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick),
      .eb_x(eb_x), .eb_y(eb_y), .enemybullet_exist(enemybullet_exist),
      .pp_x(pp_x), .pp_y(pp_y),
      .collide(collide), .player_hit(player_hit), .lives(lives),
      .invuln(invuln), .game_over(game_over), .player_visible(player_visible)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] ebx;
      logic [9:0] eby;
      logic [9:0] ppx;
      logic [9:0] ppy;
      logic       exist;
      logic       exp_hit;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic do_tick();
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk) rst = 1'b0;
      @(negedge clk) rst = 1'b1;
   endtask

   task automatic set_in(input int ex, input int ey, input int px, input int py, input logic ex_on);
      eb_x = 10'(ex);
      eb_y = 10'(ey);
      pp_x = 10'(px);
      pp_y = 10'(py);
      enemybullet_exist = ex_on;
   endtask

   task automatic release_collide();
      @(negedge clk) enemybullet_exist = 1'b0;
      @(negedge clk);
      check("collide_release", int'(collide), 1);
      enemybullet_exist = 1'b1;
   endtask

   initial begin
      int pulses;
      int exp_vis;

      vecs[0]  = '{10'd110, 10'd790, 10'd100, 10'd300, 1'b1, 1'b1};
      vecs[1]  = '{10'd140, 10'd790, 10'd100, 10'd300, 1'b1, 1'b0};
      vecs[2]  = '{10'd90,  10'd790, 10'd100, 10'd300, 1'b1, 1'b0};
      vecs[3]  = '{10'd91,  10'd790, 10'd100, 10'd300, 1'b1, 1'b1};
      vecs[4]  = '{10'd139, 10'd790, 10'd100, 10'd300, 1'b1, 1'b1};
      vecs[5]  = '{10'd110, 10'd479, 10'd100, 10'd0,   1'b1, 1'b0};
      vecs[6]  = '{10'd110, 10'd480, 10'd100, 10'd0,   1'b1, 1'b1};
      vecs[7]  = '{10'd110, 10'd961, 10'd100, 10'd470, 1'b1, 1'b0};
      vecs[8]  = '{10'd110, 10'd960, 10'd100, 10'd470, 1'b1, 1'b1};
      vecs[9]  = '{10'd110, 10'd740, 10'd100, 10'd300, 1'b1, 1'b0};
      vecs[10] = '{10'd110, 10'd741, 10'd100, 10'd300, 1'b1, 1'b1};
      vecs[11] = '{10'd110, 10'd820, 10'd100, 10'd300, 1'b1, 1'b0};
      vecs[12] = '{10'd110, 10'd819, 10'd100, 10'd300, 1'b1, 1'b1};
      vecs[13] = '{10'd110, 10'd790, 10'd100, 10'd300, 1'b0, 1'b0};

      // Reset state
      #12;
      check("rst_lives", int'(lives), 3);
      check("rst_collide", int'(collide), 1);
      check("rst_invuln", int'(invuln), 0);
      check("rst_game_over", int'(game_over), 0);
      check("rst_visible", int'(player_visible), 1);
      check("rst_player_hit", int'(player_hit), 0);
      @(negedge clk) rst = 1'b1;

      // Overlap table: one tick per vector from a fresh reset
      for (int i = 0; i < 14; i++) begin
         do_reset();
         set_in(int'(vecs[i].ebx), int'(vecs[i].eby), int'(vecs[i].ppx),
                int'(vecs[i].ppy), vecs[i].exist);
         do_tick();
         check($sformatf("vec%0d_hit", i), int'(player_hit), int'(vecs[i].exp_hit));
         check($sformatf("vec%0d_lives", i), int'(lives), vecs[i].exp_hit ? 2 : 3);
      end

      // Hit, then collide stays low while bullet persists
      do_reset();
      set_in(110, 790, 100, 300, 1'b1);
      do_tick();
      check("a_hit", int'(player_hit), 1);
      check("a_lives", int'(lives), 2);
      check("a_collide", int'(collide), 0);
      check("a_invuln", int'(invuln), 1);
      @(negedge clk);
      check("a_hit_one_cycle", int'(player_hit), 0);
      for (int i = 0; i < 5; i++) do_tick();
      check("a_collide_held", int'(collide), 0);
      check("a_lives_held", int'(lives), 2);
      for (int i = 0; i < 55; i++) do_tick();
      check("a_back_alive", int'(invuln), 0);
      do_tick();
      check("a_no_hit_collide_low", int'(player_hit), 0);
      check("a_lives_collide_low", int'(lives), 2);
      check("a_collide_still_low", int'(collide), 0);
      release_collide();

      // Invulnerability timing: 60 ticks, hit on the last tick ignored
      do_reset();
      set_in(110, 790, 100, 300, 1'b1);
      do_tick();
      check("b_hit", int'(player_hit), 1);
      release_collide();
      repeat (6) @(negedge clk);
      check("b_no_tick_hold", int'(invuln), 1);
      pulses = 0;
      for (int i = 1; i <= 59; i++) begin
         do_tick();
         pulses += int'(player_hit);
      end
      check("b_pulses_during_invuln", pulses, 0);
      check("b_invuln_tick59", int'(invuln), 1);
      check("b_lives_tick59", int'(lives), 2);
      do_tick();
      check("b_invuln_tick60", int'(invuln), 0);
      check("b_hit_tick60", int'(player_hit), 0);
      check("b_lives_tick60", int'(lives), 2);
      do_tick();
      check("b_hit_tick61", int'(player_hit), 1);
      check("b_lives_tick61", int'(lives), 1);

      // Game over from the last life
      release_collide();
      for (int i = 0; i < 60; i++) do_tick();
      do_tick();
      check("c_hit_last", int'(player_hit), 1);
      check("c_lives_zero", int'(lives), 0);
      check("c_game_over", int'(game_over), 1);
      check("c_invuln_off", int'(invuln), 0);
      check("c_visible_off", int'(player_visible), 0);
      release_collide();
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         do_tick();
         pulses += int'(player_hit);
      end
      check("c_no_pulse_over", pulses, 0);
      check("c_lives_hold", int'(lives), 0);
      check("c_over_hold", int'(game_over), 1);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("c_rst_game_over", int'(game_over), 0);
      check("c_rst_lives", int'(lives), 3);
      check("c_rst_visible", int'(player_visible), 1);
      @(negedge clk) rst = 1'b1;

      // Async reset mid-INVULN (counter 30), visibility pattern
      do_reset();
      set_in(110, 790, 100, 300, 1'b1);
      do_tick();
      check("d_hit", int'(player_hit), 1);
      for (int i = 1; i <= 30; i++) begin
         do_tick();
`ifdef HIT_BLINK_EN
         exp_vis = (i / 4) % 2;
`else
         exp_vis = 1;
`endif
         check($sformatf("d_visible_t%0d", i), int'(player_visible), exp_vis);
      end
      #2 rst = 1'b0;
      #1;
      check("d_rst_lives", int'(lives), 3);
      check("d_rst_invuln", int'(invuln), 0);
      check("d_rst_collide", int'(collide), 1);
      check("d_rst_visible", int'(player_visible), 1);
      @(negedge clk) rst = 1'b1;
      do_tick();
      check("d_resume_hit", int'(player_hit), 1);
      check("d_resume_lives", int'(lives), 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/enemy_hit_judge.md
ENEMY_HIT_JUDGE -- requirements
Module: enemy_hit_judge

Interface
REQ-001 Parameter LIVES_INIT, default 3: lives loaded at reset (1..7).
REQ-002 Parameter INVULN_FRAMES, default 60: frames of invulnerability after a hit (1..255).
REQ-003 Parameters PLANE_W, PLANE_H, default 40, 40: player plane hitbox size in pixels.
REQ-004 clk  in  1  system clock; every register is clocked on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 frame_tick  in  1  one-cycle pulse per video frame; all evaluation is gated by it.
REQ-007 eb_x, eb_y  in  10 each  enemy bullet top-left; eb_y is in virtual space, where screen y = eb_y - 480.
REQ-008 enemybullet_exist  in  1  1 = bullet is live.
REQ-009 pp_x, pp_y  in  10 each  player plane top-left, in screen space.
REQ-010 collide  out  1  active-low hit flag to the bullet stage; 0 = bullet has hit.
REQ-011 player_hit  out  1  one-cycle pulse on each registered hit.
REQ-012 lives  out  3  remaining lives.
REQ-013 invuln  out  1  1 while the player is invulnerable.
REQ-014 game_over  out  1  1 once lives reach 0.
REQ-015 player_visible  out  1  render enable for the player plane.

Function
REQ-016 Overlap SHALL use 11-bit arithmetic, with sy = eb_y - 480 and a 10x40 bullet box.
REQ-017 Overlap is true only when all of these hold: eb_y >= 480; eb_y <= 960; eb_x < pp_x+PLANE_W; eb_x+10 > pp_x; sy < pp_y+PLANE_H; sy+40 > pp_y.
REQ-018 Boxes that only touch at an edge SHALL NOT overlap.
REQ-019 FSM states SHALL be ALIVE, INVULN and OVER.
REQ-020 In ALIVE, a hit is frame_tick & enemybullet_exist & overlap & collide==1.
REQ-021 On a hit, on the same clock edge: lives decrements; player_hit=1 for exactly one cycle; collide goes to 0.
REQ-022 On a hit, if the new lives value is 0, the next state SHALL be OVER; otherwise INVULN, with the frame counter loaded with INVULN_FRAMES.
REQ-023 In INVULN, each frame_tick SHALL decrement the counter; the tick on which the counter reaches 0 SHALL move the FSM to ALIVE.
REQ-024 In INVULN, overlaps SHALL be ignored.
REQ-025 OVER SHALL be terminal until reset; game_over=1 in OVER; lives SHALL hold 0 and never wrap.
REQ-026 Collide handshake: once 0, collide SHALL stay 0 until enemybullet_exist is sampled 0, and SHALL return to 1 on the following clock edge.
REQ-027 While collide==0, no new hit SHALL be registered.
REQ-028 A hit coincident with the last INVULN tick SHALL NOT register; the FSM enters ALIVE and the overlap is evaluated at the next tick.
REQ-029 Without frame_tick, no state, lives or counter change SHALL occur; only the collide release of REQ-026 is exempt.
REQ-030 invuln SHALL be 1 exactly when the state is INVULN.
REQ-031 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-032 While rst=0, every register SHALL hold its reset value, asynchronously.
REQ-033 Reset values: state=ALIVE; lives=LIVES_INIT; counter=0; collide=1; player_hit=0; invuln=0; game_over=0; player_visible=1.
REQ-034 Reset asserted mid-INVULN or in OVER SHALL return the block to the REQ-033 values immediately.
REQ-035 Operation SHALL resume on the first clk edge after rst returns to 1.

Configuration
REQ-036 Macro HIT_BLINK_EN, when defined: in INVULN, player_visible SHALL toggle on every 4th frame_tick, starting at 0 on the hit.
REQ-037 With HIT_BLINK_EN defined: player_visible=1 in ALIVE and 0 in OVER.
REQ-038 Without HIT_BLINK_EN: player_visible = ~game_over, and no blink counter SHALL be synthesized.

Verification
REQ-039 Hit: pp=(100,300), eb=(110,790), enemybullet_exist=1, tick -> player_hit pulse, lives 3->2, collide=0, invuln=1.
REQ-040 Collide release: hold enemybullet_exist=1 for 5 ticks -> collide stays 0 and lives stay 2; drop exist to 0 -> collide=1 one clock later.
REQ-041 Edge, INVULN timing: eb=(140,790) with pp_x=100 -> no hit (touching edge); after a hit, 60 ticks -> invuln clears on the 60th, and a hit 1 tick earlier is ignored.
REQ-042 Edge, screen window: eb_y=479 or eb_y=961 with a box that would otherwise overlap -> no hit.
REQ-043 Game over: 3 separated hits -> lives 0 and game_over=1; further overlaps -> no pulse and lives stay 0.
REQ-044 Reset: assert rst=0 mid-INVULN (counter=30) -> lives=3, invuln=0, collide=1 without waiting for a clk edge; with HIT_BLINK_EN, player_visible shows 0/1 in 4-tick periods during INVULN.
